// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// access sizes and the split/legality predicates.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} lsu_state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} access_size_t;

  function automatic access_size_t access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  // An access spills into the next word when offset + size runs past byte 3.
  function automatic logic is_split(input access_size_t size, input logic [1:0] offset);
    case (size)
      HALF:    return offset == 2'd3;
      WORD:    return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_supported(input logic we, input logic [2:0] funct3);
    if (we)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: store byte enables
// and lane-positioned data for both words, and load shift/extension.
module lsu_align import lsu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] word0,
  input  logic [DATA_W-1:0] word1,
  output logic [3:0]        wr0,
  output logic [3:0]        wr1,
  output logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);

  logic [3:0]          mask;
  logic [7:0]          lanes;
  logic [2*DATA_W-1:0] st_wide;
  logic [DATA_W-1:0]   ld_low;

  // Store path: the upper half of the 8-lane window is what spills into word1.
  always_comb begin
    mask = 4'b1111;
    case (access_size(funct3))
      BYTE:    mask = 4'b0001;
      HALF:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    lanes   = {4'b0000, mask} << offset;
    st_wide = {{DATA_W{1'b0}}, wdata} << {offset, 3'b000};
    wr0     = lanes[3:0];
    wr1     = lanes[7:4];
    wdata0  = '0;
    wdata1  = '0;
    for (int i = 0; i < 4; i++) begin
      if (wr0[i]) wdata0[8*i +: 8] = st_wide[8*i +: 8];
      if (wr1[i]) wdata1[8*i +: 8] = st_wide[DATA_W + 8*i +: 8];
    end
  end

  always_comb begin
    ld_low = DATA_W'({word1, word0} >> {offset, 3'b000});
    rdata  = '0;
    case (funct3)
      F3_B:    rdata = {{(DATA_W-8){ld_low[7]}}, ld_low[7:0]};
      F3_H:    rdata = {{(DATA_W-16){ld_low[15]}}, ld_low[15:0]};
      F3_W:    rdata = ld_low;
      F3_BU:   rdata = {{(DATA_W-8){1'b0}}, ld_low[7:0]};
      F3_HU:   rdata = {{(DATA_W-16){1'b0}}, ld_low[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a RISC-V core and a word-organised data memory.
// Define LSU_MISALIGNED_EN to allow accesses that straddle two words.
module load_store_unit import lsu_pkg::*; #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int WA_W = DM_ADDRESS - 2;

`ifdef LSU_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_t        state;
  logic              we_q;
  logic              split_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [3:0]        wr1_q;
  logic [DATA_W-1:0] wdata1_q;
  logic [DATA_W-1:0] word0_q;

  logic              in_idle;
  logic              req_split;
  logic              req_reject;
  logic [2:0]        al_funct3;
  logic [1:0]        al_offset;
  logic [DATA_W-1:0] al_word0;
  logic [DATA_W-1:0] al_word1;
  logic [3:0]        al_wr0;
  logic [3:0]        al_wr1;
  logic [DATA_W-1:0] al_wdata0;
  logic [DATA_W-1:0] al_wdata1;
  logic [DATA_W-1:0] al_rdata;

  // The aligner sees the incoming request while idle (store lanes are
  // registered at accept) and the latched request afterwards (load result).
  assign in_idle    = (state == IDLE);
  assign al_funct3  = in_idle ? req_funct3 : funct3_q;
  assign al_offset  = in_idle ? req_addr[1:0] : offset_q;
  assign al_word0   = split_q ? word0_q : mem_rdata;
  assign al_word1   = split_q ? mem_rdata : '0;
  assign req_split  = is_split(access_size(req_funct3), req_addr[1:0]);
  assign req_reject = !is_supported(req_we, req_funct3) || (req_split && !SPLIT_EN);

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3 (al_funct3),
    .offset (al_offset),
    .wdata  (req_wdata),
    .word0  (al_word0),
    .word1  (al_word1),
    .wr0    (al_wr0),
    .wr1    (al_wr1),
    .wdata0 (al_wdata0),
    .wdata1 (al_wdata1),
    .rdata  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_wr    <= 4'b0000;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      split_q   <= 1'b0;
      funct3_q  <= '0;
      offset_q  <= '0;
      wr1_q     <= 4'b0000;
      wdata1_q  <= '0;
      word0_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            split_q   <= req_split;
            funct3_q  <= req_funct3;
            offset_q  <= req_addr[1:0];
            wr1_q     <= al_wr1;
            wdata1_q  <= al_wdata1;
            req_ready <= 1'b0;
            if (req_reject) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ACC0;
              mem_addr  <= req_addr[DM_ADDRESS-1:2];
              mem_re    <= !req_we;
              mem_wr    <= req_we ? al_wr0 : 4'b0000;
              mem_wdata <= req_we ? al_wdata0 : '0;
            end
          end
        end
        ACC0: begin
          if (split_q && SPLIT_EN) begin
            state     <= ACC1;
            mem_addr  <= mem_addr + WA_W'(1);
            mem_re    <= !we_q;
            mem_wr    <= we_q ? wr1_q : 4'b0000;
            mem_wdata <= we_q ? wdata1_q : '0;
          end else begin
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_wr    <= 4'b0000;
            mem_wdata <= '0;
            if (we_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        ACC1: begin
          word0_q   <= mem_rdata;
          mem_addr  <= '0;
          mem_re    <= 1'b0;
          mem_wr    <= 4'b0000;
          mem_wdata <= '0;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        // mem_rdata now holds the last word read, so the result is final here.
        WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= al_rdata;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
